// File: rtl/bbuf_loader_pkg.sv
// Shared constants, FSM encoding and burst sizing helpers for the bias-buffer loader.
// Imported by bbuf_loader.

package bbuf_loader_pkg;

    localparam int MEM_DATA_WIDTH = 256;
    localparam int BUF_ADDR_WIDTH = 9;
    localparam int BUF_ID_W       = 2;
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W;
    localparam int EXT_ADDR_W     = 32;
    localparam int MAX_BURST      = 16;
    localparam int LEN_W          = 5;
    localparam int ROW_CNT_W      = 10;

    localparam int BEATS_PER_ROW  = 4;
    localparam int BYTES_PER_BEAT = 32;

    // Beat totals are rows*4, so two extra bits over the row count.
    localparam int TOTAL_BEATS_W  = ROW_CNT_W + BUF_ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [LEN_W-1:0] burst_len(input logic [TOTAL_BEATS_W-1:0] remaining);
        if (remaining >= TOTAL_BEATS_W'(MAX_BURST)) begin
            return LEN_W'(MAX_BURST);
        end
        return remaining[LEN_W-1:0];
    endfunction

    function automatic logic [EXT_ADDR_W-1:0] burst_bytes(input logic [LEN_W-1:0] len);
        return EXT_ADDR_W'(len) << $clog2(BYTES_PER_BEAT);
    endfunction

endpackage

// File: rtl/bbuf_loader.sv
// DMA-side write initiator: fetches bias rows from external memory in bursts
// and writes them into the banked bias buffer, four 256-bit beats per row.

module bbuf_loader
    import bbuf_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [EXT_ADDR_W-1:0]     cfg_ext_addr,
    input  logic [BUF_ADDR_WIDTH-1:0] cfg_buf_base,
    input  logic [ROW_CNT_W-1:0]      cfg_num_rows,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_req_valid,
    input  logic                      rd_req_ready,
    output logic [EXT_ADDR_W-1:0]     rd_req_addr,
    output logic [LEN_W-1:0]          rd_req_len,
    input  logic                      rd_data_valid,
    output logic                      rd_data_ready,
    input  logic [MEM_DATA_WIDTH-1:0] rd_data,
    output logic                      mem_write_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_write_data
);

    state_t state, state_next;

    logic [EXT_ADDR_W-1:0]     ext_addr;
    logic [BUF_ADDR_WIDTH-1:0] buf_base;
    logic [TOTAL_BEATS_W-1:0]  beats_unreq;
    logic [LEN_W-1:0]          burst_left;
    // Only the low 11 bits of the beat index matter: the row part wraps mod 512 anyway.
    logic [MEM_ADDR_WIDTH-1:0] beat_idx;
    logic [BUF_ADDR_WIDTH-1:0] row_addr;

    logic req_fire;
    logic beat_fire;

    assign req_fire    = rd_req_valid && rd_req_ready;
    assign beat_fire   = rd_data_valid && rd_data_ready;
    assign rd_req_addr = ext_addr;
    assign rd_req_len  = burst_len(beats_unreq);
    assign row_addr    = buf_base + beat_idx[MEM_ADDR_WIDTH-1:BUF_ID_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        busy          = (state != IDLE);
        done          = 1'b0;
        rd_req_valid  = 1'b0;
        rd_data_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (cfg_num_rows == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                rd_req_valid = 1'b1;
                if (rd_req_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                rd_data_ready = 1'b1;
                if (rd_data_valid && burst_left == LEN_W'(1)) begin
                    state_next = (beats_unreq == '0) ? DONE : REQ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command bookkeeping: external address, unrequested beats and the live burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_addr    <= '0;
            buf_base    <= '0;
            beats_unreq <= '0;
            burst_left  <= '0;
            beat_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ext_addr    <= cfg_ext_addr;
                        buf_base    <= cfg_buf_base;
                        beats_unreq <= {cfg_num_rows, 2'b00};
                        burst_left  <= '0;
                        beat_idx    <= '0;
                    end
                end
                REQ: begin
                    if (req_fire) begin
                        ext_addr    <= ext_addr + burst_bytes(rd_req_len);
                        beats_unreq <= beats_unreq - TOTAL_BEATS_W'(rd_req_len);
                        burst_left  <= rd_req_len;
                    end
                end
                DATA: begin
                    if (beat_fire) begin
                        burst_left <= burst_left - LEN_W'(1);
                        beat_idx   <= beat_idx + MEM_ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Single registered write stage; a pending write is simply dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_write_req  <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            mem_write_req <= beat_fire;
            if (beat_fire) begin
                mem_write_addr <= {row_addr, beat_idx[BUF_ID_W-1:0]};
                mem_write_data <= rd_data;
            end
        end
    end

endmodule
